// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
// Module      : int_controller
// Description : Memory-mapped 4-source interrupt controller with fixed priority
//               and EOI handshake. Optional service watchdog: INTC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module int_controller #(
    parameter logic [7:0] BASE_ADDR       = 8'hF0,
    parameter int         VEC_STRIDE_LOG2 = 2,
    parameter int         TIMEOUT_CYCLES  = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] irq_src,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_w_data,
    input  logic       mem_w_en,
    output logic [7:0] bus_r_data,
    output logic       int_req,
    output logic [7:0] int_en,
    output logic [7:0] int_vec
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_REQ     = 2'd1;
    localparam logic [1:0] c_S_SERVICE = 2'd2;

    localparam logic [1:0] c_REG_CTRL  = 2'd0;
    localparam logic [1:0] c_REG_VEC   = 2'd1;
    localparam logic [1:0] c_REG_PEND  = 2'd2;
    localparam logic [1:0] c_REG_STAT  = 2'd3;

    logic [7:0] r_ctrl;
    logic [7:0] r_vec_base;
    logic [3:0] r_pending;
    logic [1:0] r_state;
    logic [1:0] r_active_id;
    logic       r_int_req;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_sync_d;

    logic [7:0] w_offset;
    logic       w_in_range;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_vec;
    logic       w_wr_pend;
    logic       w_wr_stat;
    logic       w_eoi;
    logic [3:0] w_rise;
    logic [3:0] w_qual;
    logic [1:0] w_sel_id;
    logic       w_accept;
    logic [3:0] w_acc_clr;
    logic [3:0] w_w1c;
    logic       w_timeout;
    logic       w_timeout_err;
    logic [7:0] w_vec_off;
    logic [7:0] w_rd_data;

    // Offset-based decode keeps the window correct for any BASE_ADDR alignment
    assign w_offset   = bus_addr - BASE_ADDR;
    assign w_in_range = (w_offset[7:2] == 6'd0);
    assign w_wr       = mem_w_en && w_in_range;
    assign w_wr_ctrl  = w_wr && (w_offset[1:0] == c_REG_CTRL);
    assign w_wr_vec   = w_wr && (w_offset[1:0] == c_REG_VEC);
    assign w_wr_pend  = w_wr && (w_offset[1:0] == c_REG_PEND);
    assign w_wr_stat  = w_wr && (w_offset[1:0] == c_REG_STAT);
    assign w_eoi      = w_wr_stat && (r_state == c_S_SERVICE);

    assign w_rise     = r_sync2 & ~r_sync_d;
    assign w_qual     = r_pending & r_ctrl[7:4];
    assign w_accept   = (r_state == c_S_IDLE) && r_ctrl[0] && (|w_qual) && !w_wr_ctrl;
    assign w_w1c      = w_wr_pend ? bus_w_data[3:0] : 4'b0000;

    always_comb begin
        w_sel_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_sel_id = 2'(i);
            end
        end
    end

    always_comb begin
        w_acc_clr = 4'b0000;
        if (w_accept) begin
            w_acc_clr[w_sel_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 4'b0000;
            r_sync2  <= 4'b0000;
            r_sync_d <= 4'b0000;
        end else begin
            r_sync1  <= irq_src;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // A new edge beats a same-cycle W1C so no interrupt is ever lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= (r_pending & ~w_w1c & ~w_acc_clr) | w_rise;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl     <= 8'h00;
            r_vec_base <= 8'h00;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= bus_w_data;
            end
            if (w_wr_vec) begin
                r_vec_base <= bus_w_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_int_req   <= 1'b0;
            r_active_id <= 2'd0;
        end else begin
            r_int_req <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= c_S_REQ;
                        r_int_req   <= 1'b1;
                        r_active_id <= w_sel_id;
                    end
                end
                c_S_REQ: begin
                    r_state <= c_S_SERVICE;
                end
                c_S_SERVICE: begin
                    if (w_eoi || w_timeout) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

`ifdef INTC_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_to_cnt;
    logic               r_timeout_err;

    assign w_timeout     = (r_state == c_S_SERVICE) && !w_eoi && (r_to_cnt == c_CNT_LAST);
    assign w_timeout_err = r_timeout_err;

    // Held at zero outside SERVICE, so every service window starts from zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state != c_S_SERVICE) || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_CNT_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (w_wr_stat && bus_w_data[6]) begin
                r_timeout_err <= 1'b0;
            end
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign w_timeout_err    = 1'b0;
`endif

    always_comb begin
        w_rd_data = 8'h00;
        if (w_in_range) begin
            case (w_offset[1:0])
                c_REG_CTRL: w_rd_data = r_ctrl;
                c_REG_VEC:  w_rd_data = r_vec_base;
                c_REG_PEND: w_rd_data = {4'b0000, r_pending};
                default:    w_rd_data = {(r_state != c_S_IDLE), w_timeout_err, 4'b0000, r_active_id};
            endcase
        end
    end

    assign w_vec_off  = 8'(r_active_id) << VEC_STRIDE_LOG2;
    assign int_vec    = r_vec_base + w_vec_off;
    assign int_en     = r_ctrl;
    assign int_req    = r_int_req;
    assign bus_r_data = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_controller
// Description : Scoreboard bench for int_controller (queued expectations,
//               negedge monitor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_src = 4'b0000;
    logic [7:0] bus_addr = 8'h00;
    logic [7:0] bus_w_data = 8'h00;
    logic       mem_w_en = 1'b0;
    logic [7:0] bus_r_data;
    logic       int_req;
    logic [7:0] int_en;
    logic [7:0] int_vec;

    always #5 clock = ~clock;

    int_controller #(
        .BASE_ADDR       (8'hF0),
        .VEC_STRIDE_LOG2 (2),
        .TIMEOUT_CYCLES  (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .bus_addr   (bus_addr),
        .bus_w_data (bus_w_data),
        .mem_w_en   (mem_w_en),
        .bus_r_data (bus_r_data),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_vec    (int_vec)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected requests: vector and the cycle it must appear on (0 = any)
    logic [7:0] exp_vec_q[$];
    int         exp_cyc_q[$];
    // Expected observations: 0 = bus_r_data, 1 = int_vec, 2 = int_en
    logic [1:0] chk_kind_q[$];
    logic [7:0] chk_val_q[$];
    string      chk_name_q[$];

    logic chk_valid  = 1'b0;
    logic finish_req = 1'b0;
    logic prev_req   = 1'b0;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] m_kind;
    logic [7:0] m_exp;
    logic [7:0] m_act;
    string      m_name;
    logic [7:0] m_ev;
    int         m_ec;

    always @(negedge clock) begin
        if (chk_valid) begin
            m_kind = chk_kind_q.pop_front();
            m_exp  = chk_val_q.pop_front();
            m_name = chk_name_q.pop_front();
            case (m_kind)
                2'd0:    m_act = bus_r_data;
                2'd1:    m_act = int_vec;
                default: m_act = int_en;
            endcase
            total++;
            if (m_act !== m_exp) begin
                bad++;
                $display("FAIL %s: got %02h expected %02h", m_name, m_act, m_exp);
            end
        end
        if (!reset && int_req) begin
            total++;
            if (prev_req) begin
                bad++;
                $display("FAIL req_twice: int_req high two cycles in a row at cycle %0d, expected single pulse", cyc);
            end else if (exp_vec_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_req: int_req=1 vec=%02h at cycle %0d, expected no request", int_vec, cyc);
            end else begin
                m_ev = exp_vec_q.pop_front();
                m_ec = exp_cyc_q.pop_front();
                if ((int_vec !== m_ev) || ((m_ec != 0) && (cyc != m_ec))) begin
                    bad++;
                    $display("FAIL req: got vec=%02h cycle=%0d expected vec=%02h cycle=%0d", int_vec, cyc, m_ev, m_ec);
                end
            end
        end
        prev_req = reset ? 1'b0 : int_req;
        if (finish_req) begin
            total++;
            if (exp_vec_q.size() != 0) begin
                bad++;
                $display("FAIL missing_req: got %0d outstanding requests expected 0", exp_vec_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus_addr   = addr;
        bus_w_data = data;
        mem_w_en   = 1'b1;
        tick();
        mem_w_en   = 1'b0;
    endtask

    task automatic chk(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] val, input string name);
        if (kind == 2'd0) bus_addr = addr;
        chk_kind_q.push_back(kind);
        chk_val_q.push_back(val);
        chk_name_q.push_back(name);
        chk_valid = 1'b1;
        @(negedge clock);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic expect_req(input logic [7:0] vec, input int dly);
        exp_vec_q.push_back(vec);
        exp_cyc_q.push_back(cyc + dly);
    endtask

    // Sources go high just after edge 'start'; first sampled at start+1
    task automatic pulse_req(input logic [3:0] bits, input logic do_exp, input logic [7:0] vec, output int start);
        tick();
        start = cyc;
        if (do_exp) expect_req(vec, 4);
        irq_src = irq_src | bits;
        tick();
        tick();
        irq_src = irq_src & ~bits;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk(0, 8'hF0, 8'h00, "rst_ctrl");
        chk(0, 8'hF1, 8'h00, "rst_vec_base");
        chk(0, 8'hF2, 8'h00, "rst_pending");
        chk(0, 8'hF3, 8'h00, "rst_status");
        chk(0, 8'h10, 8'h00, "rst_out_of_range");
        chk(1, 8'h00, 8'h00, "rst_int_vec");
        chk(2, 8'h00, 8'h00, "rst_int_en");

        // Single source, exact latency
        wr(8'hF0, 8'hF1);
        wr(8'hF1, 8'h40);
        chk(2, 8'h00, 8'hF1, "int_en_f1");
        chk(0, 8'hF1, 8'h40, "vec_base_rd");
        chk(0, 8'hF4, 8'h00, "out_of_range_f4");
        pulse_req(4'b0100, 1'b1, 8'h48, s);
        repeat (6) tick();
        chk(1, 8'h00, 8'h48, "vec_id2");
        chk(0, 8'hF3, 8'h82, "status_svc_id2");
        chk(0, 8'hF2, 8'h00, "pend_after_id2");

        // Two sources while in service, resolved by priority after each EOI
        pulse_req(4'b1010, 1'b0, 8'h00, s);
        repeat (4) tick();
        chk(0, 8'hF2, 8'h0A, "pend_3_and_1");
        expect_req(8'h44, 2);
        wr(8'hF3, 8'h00);
        repeat (4) tick();
        chk(0, 8'hF3, 8'h81, "status_svc_id1");
        chk(0, 8'hF2, 8'h08, "pend_only_3");
        expect_req(8'h4C, 2);
        wr(8'hF3, 8'h00);
        repeat (4) tick();
        chk(0, 8'hF3, 8'h83, "status_svc_id3");
        chk(0, 8'hF2, 8'h00, "pend_empty");
        chk(1, 8'h00, 8'h4C, "vec_id3");
        wr(8'hF3, 8'h00);
        repeat (8) tick();
        chk(0, 8'hF3, 8'h03, "status_idle_id3");

        // Global enable off keeps pending; enabling issues the request
        wr(8'hF0, 8'h20);
        pulse_req(4'b0010, 1'b0, 8'h00, s);
        repeat (5) tick();
        chk(0, 8'hF2, 8'h02, "pend_disabled");
        chk(2, 8'h00, 8'h20, "int_en_20");
        expect_req(8'h44, 2);
        wr(8'hF0, 8'h21);
        repeat (4) tick();
        chk(0, 8'hF3, 8'h81, "status_after_enable");
        wr(8'hF3, 8'h00);
        tick();

        // W1C colliding with a new edge on the same (masked) source
        pulse_req(4'b0100, 1'b0, 8'h00, s);
        repeat (4) tick();
        chk(0, 8'hF2, 8'h04, "pend_src2_masked");
        tick();
        irq_src[2] = 1'b1;
        tick();
        tick();
        wr(8'hF2, 8'h04);
        chk(0, 8'hF2, 8'h04, "w1c_collide_set_wins");
        irq_src[2] = 1'b0;
        wr(8'hF2, 8'h04);
        chk(0, 8'hF2, 8'h00, "w1c_clear");

        // EOI in IDLE is ignored; reset mid-service
        wr(8'hF3, 8'h00);
        repeat (3) tick();
        chk(0, 8'hF3, 8'h01, "eoi_in_idle");
        pulse_req(4'b0010, 1'b1, 8'h44, s);
        repeat (5) tick();
        chk(0, 8'hF3, 8'h81, "svc_before_reset");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk(0, 8'hF3, 8'h00, "status_after_reset");
        chk(2, 8'h00, 8'h00, "int_en_after_reset");
        chk(1, 8'h00, 8'h00, "int_vec_after_reset");

        // Service watchdog (SERVICE entered at s+5)
        wr(8'hF0, 8'hF1);
        pulse_req(4'b0001, 1'b1, 8'h00, s);
        wait_until(s + 14);
        chk(0, 8'hF3, 8'h80, "svc_before_timeout");
        wait_until(s + 15);
`ifdef INTC_TIMEOUT_EN
        chk(0, 8'hF3, 8'h40, "timeout_status");
`else
        chk(0, 8'hF3, 8'h80, "no_timeout_status");
`endif
        wr(8'hF3, 8'h40);
        tick();
        chk(0, 8'hF3, 8'h00, "status_cleared");

        repeat (5) tick();
        finish_req = 1'b1;
        @(negedge clock);
        #1;
    end

endmodule
`default_nettype wire

// File: doc/int_controller.md
# int_controller

- Memory-mapped 8-bit interrupt controller that drives the CPU core's `int_req`, `int_en` and `int_vec` inputs.
- Latches rising edges on four external sources into pending bits and resolves them by fixed priority.
- Issues exactly one single-cycle request per accepted interrupt, then holds off further requests until software writes end-of-interrupt (EOI).
- Sits on the data-memory bus beside RAM; the CPU programs it with ordinary stores.

## Interface
Parameters:
- `BASE_ADDR`, 8'hF0: address of the first of four registers (BASE..BASE+3).
- `VEC_STRIDE_LOG2`, 2: vector spacing; `int_vec = vec_base + (id << VEC_STRIDE_LOG2)`, 8-bit wrap.
- `TIMEOUT_CYCLES`, 255: service watchdog limit; used only with `INTC_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clock`  in  1  system clock.
  - `reset`  in  1  asynchronous, active-high reset.
- `irq_src`  in  4  asynchronous interrupt sources; rising-edge triggered; bit 0 has highest priority.
- `bus_addr`  in  8  data-bus address.
- `bus_w_data`  in  8  data-bus write data.
- `mem_w_en`  in  1  write strobe; a write occurs at a clock edge where `mem_w_en`=1 and `bus_addr` is in range.
- `bus_r_data`  out  8  read data; combinational; 0 when `bus_addr` is out of range, so it can be OR-merged onto the bus.
- `int_req`  out  1  single-cycle interrupt request to the CPU.
- `int_en`  out  8  equals the CTRL register; bit 0 is the global enable.
- `int_vec`  out  8  vector for the active source.

## Operation
Registers:
- BASE+0 CTRL (R/W): bit0 global enable; bits[7:4] mask for sources 3..0 (1 = enabled); bits[3:1] read/write, no function.
- BASE+1 VEC_BASE (R/W).
- BASE+2 PENDING (R: bits[3:0], upper bits read 0; W: write-1-to-clear bits[3:0]).
- BASE+3 STATUS/EOI.
  - Read: bit7 = in_service (state != IDLE); bit6 = timeout_err; bits[1:0] = active_id; other bits 0.
  - Write: EOI. A write with bit6=1 also clears timeout_err.

Edge capture:
- Each `irq_src` bit passes through a 2-flop synchronizer and a delay flop.
- A synchronized rising edge sets its pending bit regardless of mask.
- If a set and a W1C clear hit the same bit on the same edge, the set wins.

State machine:
- States: IDLE, REQ, SERVICE.
- IDLE -> REQ when CTRL[0]=1, `(PENDING & CTRL[7:4])` is nonzero, and no CTRL write occurs in that cycle.
  - On this edge, active_id latches the lowest-index qualifying source and that pending bit clears.
- REQ -> SERVICE unconditionally after one cycle.
- SERVICE -> IDLE on EOI write.
- EOI writes in IDLE or REQ are ignored; a bit6 clear still applies.

Outputs:
- `int_req` = (state == REQ), registered. It is never high for two consecutive cycles.
- `int_vec` = VEC_BASE + (active_id << VEC_STRIDE_LOG2), combinational from registers. It is stable from REQ until the next REQ.
- Masked or globally disabled sources keep their pending bits and are requested once enabled.

## Timing
- Reset values: CTRL=0, VEC_BASE=0, PENDING=0, active_id=0, timeout_err=0, state=IDLE, synchronizer flops=0.
  - Resulting outputs: `int_req`=0, `int_en`=0, `int_vec`=0, `bus_r_data`=0 or the register value addressed.
- Latency: source first sampled high at edge N -> pending set at edge N+2 -> `int_req` high from edge N+3 to edge N+4. The CPU samples `int_req` at edge N+4.
- EOI at edge M with another qualifying source pending -> REQ at edge M+1.
- Writes take effect at the clock edge. Reads reflect register contents combinationally within the same cycle.
- Reset asserted mid-service returns the block to IDLE immediately and drops `int_req` asynchronously.

## Configuration
- Macro: `INTC_TIMEOUT_EN`.
- Defined:
  - A counter runs in SERVICE and clears on entry to SERVICE.
  - When the counter reaches `TIMEOUT_CYCLES` without an EOI, the state is forced to IDLE and timeout_err is set to 1.
  - timeout_err is sticky until a STATUS write with bit6=1 or reset.
- Undefined: no counter is built; timeout_err reads 0; SERVICE is left only by EOI.

## Test plan
- Reset, then read all four registers -> 0x00 each; `int_req`=0; `int_vec`=0x00.
- CTRL=0xF1, VEC_BASE=0x40, pulse `irq_src[2]` -> `int_req` high for exactly one cycle, 3 cycles after first sampling; `int_vec`=0x48; STATUS=0x82; PENDING=0.
- Pulse sources 3 and 1 together during SERVICE, then EOI -> REQ at the next edge with `int_vec`=VEC_BASE+4 (id 1); after a second EOI, id 3 is requested; no further request follows.
- CTRL=0x20 (global enable off), pulse source 1 -> PENDING=0x02, no `int_req`. Write CTRL=0x21 -> request issued. W1C of PENDING on the same edge as a new edge on that source -> bit stays 1.
- EOI written in IDLE -> no state change. Reset asserted while in SERVICE -> STATUS=0x00 on the next read.
- With `INTC_TIMEOUT_EN` and TIMEOUT_CYCLES=10: take an interrupt and withhold EOI -> IDLE after 10 SERVICE cycles; STATUS bit6=1; write 0x40 to STATUS -> bit6=0.
